// File: rtl/ihex_rom_exporter.sv
// Streams the first byte_count bytes of the 16-bit program ROM as ASCII Intel HEX.
// The output is a registered valid/ready character stream that ends with the EOF record.
module ihex_rom_exporter #(
    parameter int ADDR_W  = 15,
    parameter int REC_LEN = 16,
    parameter int ROM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W:0]   byte_count,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-2:0] rom_addr,
    output logic              rom_rd,
    input  logic [15:0]       rom_data,
    output logic [7:0]        out_data,
    output logic              out_valid,
    input  logic              out_ready
);

    typedef enum logic [3:0] {
        IDLE, COLON, LEN, ADDR, TYPE, FETCH, DATA, CSUM, EOL, EOF_REC, DONE
    } state_t;

    localparam logic [ADDR_W:0] MAX_BYTES = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] REC_MAX   = (ADDR_W+1)'(REC_LEN);
    localparam logic [7:0]      LAT       = 8'(ROM_LAT);

    state_t            state;
    logic [ADDR_W:0]   remaining;
    logic [ADDR_W:0]   byte_addr;
    logic [7:0]        rec_left;
    logic [7:0]        csum;
    logic [7:0]        data_byte;
    logic [1:0]        digit;
    logic [3:0]        eof_idx;
    logic [7:0]        lat_cnt;

    logic              hs;
    logic [ADDR_W:0]   clamped;
    logic [ADDR_W:0]   next_addr;
    logic [15:0]       addr16;
    logic [7:0]        rec_size;
    logic [7:0]        fetched;
    logic [7:0]        cc;

    assign hs        = out_valid & out_ready;
    assign clamped   = (byte_count > MAX_BYTES) ? MAX_BYTES : byte_count;
    assign next_addr = byte_addr + 1'b1;
    assign addr16    = 16'(byte_addr);
    assign rec_size  = (remaining < REC_MAX) ? remaining[7:0] : REC_MAX[7:0];
    assign fetched   = byte_addr[0] ? rom_data[15:8] : rom_data[7:0];
    // csum already holds every byte of the record, so the checksum is its negation
    assign cc        = 8'h00 - csum;

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    function automatic logic [7:0] eof_char(input logic [3:0] i);
        logic [7:0] c;
        case (i)
            4'd0:        c = 8'h3A;
            4'd8:        c = 8'h31;
            4'd9, 4'd10: c = 8'h46;
            4'd11:       c = 8'h0A;
            default:     c = 8'h30;
        endcase
        return c;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            rom_rd    <= 1'b0;
            rom_addr  <= '0;
            out_data  <= 8'h00;
            out_valid <= 1'b0;
            remaining <= '0;
            byte_addr <= '0;
            rec_left  <= 8'h00;
            csum      <= 8'h00;
            data_byte <= 8'h00;
            digit     <= 2'd0;
            eof_idx   <= 4'd0;
            lat_cnt   <= 8'h00;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        remaining <= clamped;
                        byte_addr <= '0;
                        busy      <= 1'b1;
                        out_valid <= 1'b1;
                        out_data  <= 8'h3A;
                        digit     <= 2'd0;
                        eof_idx   <= 4'd0;
                        state     <= (clamped == '0) ? EOF_REC : COLON;
                    end else begin
                        state <= IDLE;
                    end
                end
                // The ROM word is sampled exactly ROM_LAT cycles after the read strobe
                FETCH: begin
                    rom_rd  <= 1'b0;
                    lat_cnt <= lat_cnt + 8'd1;
                    if (lat_cnt == LAT) begin
                        data_byte <= fetched;
                        csum      <= csum + fetched;
                        out_data  <= hex_char(fetched[7:4]);
                        out_valid <= 1'b1;
                        digit     <= 2'd0;
                        state     <= DATA;
                    end
                end
                default: begin
                    if (hs) begin
                        case (state)
                            COLON: begin
                                rec_left <= rec_size;
                                csum     <= rec_size;
                                out_data <= hex_char(rec_size[7:4]);
                                digit    <= 2'd0;
                                state    <= LEN;
                            end
                            LEN: begin
                                if (digit == 2'd0) begin
                                    out_data <= hex_char(rec_left[3:0]);
                                    digit    <= 2'd1;
                                end else begin
                                    out_data <= hex_char(addr16[15:12]);
                                    digit    <= 2'd0;
                                    state    <= ADDR;
                                end
                            end
                            ADDR: begin
                                digit <= digit + 2'd1;
                                case (digit)
                                    2'd0: out_data <= hex_char(addr16[11:8]);
                                    2'd1: out_data <= hex_char(addr16[7:4]);
                                    2'd2: out_data <= hex_char(addr16[3:0]);
                                    default: begin
                                        out_data <= 8'h30;
                                        csum     <= csum + addr16[15:8] + addr16[7:0];
                                        digit    <= 2'd0;
                                        state    <= TYPE;
                                    end
                                endcase
                            end
                            TYPE: begin
                                if (digit == 2'd0) begin
                                    out_data <= 8'h30;
                                    digit    <= 2'd1;
                                end else begin
                                    out_valid <= 1'b0;
                                    rom_rd    <= 1'b1;
                                    rom_addr  <= byte_addr[ADDR_W-1:1];
                                    lat_cnt   <= 8'h00;
                                    state     <= FETCH;
                                end
                            end
                            DATA: begin
                                if (digit == 2'd0) begin
                                    out_data <= hex_char(data_byte[3:0]);
                                    digit    <= 2'd1;
                                end else begin
                                    byte_addr <= next_addr;
                                    remaining <= remaining - 1'b1;
                                    rec_left  <= rec_left - 8'd1;
                                    digit     <= 2'd0;
                                    if (rec_left == 8'd1) begin
                                        out_data <= hex_char(cc[7:4]);
                                        state    <= CSUM;
                                    end else begin
                                        out_valid <= 1'b0;
                                        rom_rd    <= 1'b1;
                                        rom_addr  <= next_addr[ADDR_W-1:1];
                                        lat_cnt   <= 8'h00;
                                        state     <= FETCH;
                                    end
                                end
                            end
                            CSUM: begin
                                if (digit == 2'd0) begin
                                    out_data <= hex_char(cc[3:0]);
                                    digit    <= 2'd1;
                                end else begin
                                    out_data <= 8'h0A;
                                    digit    <= 2'd0;
                                    state    <= EOL;
                                end
                            end
                            EOL: begin
                                out_data <= 8'h3A;
                                eof_idx  <= 4'd0;
                                state    <= (remaining != '0) ? COLON : EOF_REC;
                            end
                            EOF_REC: begin
                                if (eof_idx == 4'd11) begin
                                    out_valid <= 1'b0;
                                    busy      <= 1'b0;
                                    done      <= 1'b1;
                                    state     <= DONE;
                                end else begin
                                    eof_idx  <= eof_idx + 4'd1;
                                    out_data <= eof_char(eof_idx + 4'd1);
                                end
                            end
                            default: state <= IDLE;
                        endcase
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ihex_rom_exporter.sv
// Directed bench for ihex_rom_exporter: checks exact HEX streams, handshake holding,
// reset behaviour, clamping and a full-ROM round trip through a BINHEX-style parser.
module tb_ihex_rom_exporter;

    localparam int ADDR_W  = 8;
    localparam int REC_LEN = 16;
    localparam int ROM_LAT = 2;

    logic              clk;
    logic              rstN;
    logic              start;
    logic [ADDR_W:0]   byteCount;
    logic              busy;
    logic              done;
    logic [ADDR_W-2:0] romAddr;
    logic              romRd;
    logic [15:0]       romData;
    logic [15:0]       romStage;
    logic [7:0]        outData;
    logic              outValid;
    logic              outReady;

    logic [7:0] romMem[256];
    logic [7:0] reloadMem[256];
    logic [7:0] gotQ[$];
    logic [7:0] expQ[$];
    string      hexDigits = "0123456789ABCDEF";
    int         checkCount = 0;
    int         failCount = 0;
    int         doneCount;
    int         rdCount;
    int         parsePos;
    int         parseErr;

    ihex_rom_exporter #(.ADDR_W(ADDR_W), .REC_LEN(REC_LEN), .ROM_LAT(ROM_LAT)) dut (
        .clk(clk), .rst_n(rstN), .start(start), .byte_count(byteCount),
        .busy(busy), .done(done), .rom_addr(romAddr), .rom_rd(romRd),
        .rom_data(romData), .out_data(outData), .out_valid(outValid),
        .out_ready(outReady)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Two-stage ROM pipeline; garbage appears whenever no read was issued
    always @(posedge clk) begin
        romStage <= romRd ? {romMem[{romAddr, 1'b1}], romMem[{romAddr, 1'b0}]} : 16'hDEAD;
        romData  <= romStage;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    function automatic void pushHex(input logic [7:0] b);
        expQ.push_back(hexDigits[b[7:4]]);
        expQ.push_back(hexDigits[b[3:0]]);
    endfunction

    function automatic void loadExpectedString(input string s);
        expQ.delete();
        for (int i = 0; i < s.len(); i++) expQ.push_back(s[i]);
    endfunction

    // Reference Intel HEX writer for the current romMem contents
    function automatic void buildExpected(input int count);
        int addr = 0;
        string eofRec = ":00000001FF\n";
        expQ.delete();
        while (addr < count) begin
            int ll = (count - addr < REC_LEN) ? count - addr : REC_LEN;
            logic [7:0] sum = 8'(ll) + 8'(addr >> 8) + 8'(addr);
            expQ.push_back(8'h3A);
            pushHex(8'(ll));
            pushHex(8'(addr >> 8));
            pushHex(8'(addr));
            pushHex(8'h00);
            for (int i = 0; i < ll; i++) begin
                pushHex(romMem[addr + i]);
                sum = sum + romMem[addr + i];
            end
            pushHex(8'h00 - sum);
            expQ.push_back(8'h0A);
            addr += ll;
        end
        for (int i = 0; i < eofRec.len(); i++) expQ.push_back(eofRec[i]);
    endfunction

    task automatic compareStreams(input string tag);
        checkOutput({tag, "_len"}, gotQ.size(), expQ.size());
        for (int i = 0; i < gotQ.size() && i < expQ.size(); i++)
            checkOutput($sformatf("%s_char%0d", tag, i), gotQ[i], expQ[i]);
    endtask

    task automatic applyStimulus(input int count, input bit randReady, input int pokeAt, input int maxCycles);
        bit finished = 0;
        bit prevValid = 0;
        bit prevReady = 1;
        bit prevLf = 0;
        logic [7:0] prevData = 8'h00;
        gotQ.delete();
        doneCount = 0;
        rdCount = 0;
        @(negedge clk);
        byteCount = (ADDR_W+1)'(count);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int cyc = 0; cyc < maxCycles && !finished; cyc++) begin
            if (cyc > 0) @(negedge clk);
            start = (cyc == pokeAt);
            if (cyc == pokeAt) byteCount = 1;
            outReady = randReady ? ($urandom_range(0, 99) < 40) : 1'b1;
            #1;
            if (cyc == 0) checkOutput("start_latency", {busy, outValid, outData}, {1'b1, 1'b1, 8'h3A});
            if (romRd) rdCount++;
            if (prevValid && !prevReady) checkOutput("hold_stable", {outValid, outData}, {1'b1, prevData});
            if (done) begin
                doneCount++;
                finished = 1;
                checkOutput("done_busy_low", busy, 0);
                checkOutput("done_after_lf", prevLf, 1);
            end
            prevLf = outValid && outReady && (outData == 8'h0A);
            if (outValid && outReady) gotQ.push_back(outData);
            prevValid = outValid;
            prevReady = outReady;
            prevData = outData;
        end
        start = 1'b0;
        checkOutput("finished_in_budget", finished, 1);
        repeat (3) begin
            @(negedge clk);
            #1;
            if (done) doneCount++;
        end
    endtask

    function automatic logic [3:0] nibble(input logic [7:0] c);
        return (c >= 8'h41) ? 4'(c - 8'h37) : 4'(c - 8'h30);
    endfunction

    function automatic logic [7:0] readHexByte();
        logic [7:0] b = 8'h00;
        if (parsePos + 1 < gotQ.size()) b = {nibble(gotQ[parsePos]), nibble(gotQ[parsePos + 1])};
        else parseErr++;
        parsePos += 2;
        return b;
    endfunction

    // Loader-side model: parse the captured stream back into reloadMem
    task automatic parseBinhex(output int dataRecs, output int eofSeen);
        dataRecs = 0;
        eofSeen = 0;
        parsePos = 0;
        parseErr = 0;
        for (int i = 0; i < 256; i++) reloadMem[i] = 8'h00;
        while (parsePos < gotQ.size() && eofSeen == 0 && parseErr == 0) begin
            logic [7:0] ll, ah, al, tt, d, sum;
            if (gotQ[parsePos] != 8'h3A) begin parseErr++; break; end
            parsePos++;
            ll = readHexByte(); ah = readHexByte(); al = readHexByte(); tt = readHexByte();
            sum = ll + ah + al + tt;
            for (int i = 0; i < int'(ll); i++) begin
                d = readHexByte();
                sum = sum + d;
                if (tt == 8'h00 && ah == 8'h00 && int'(al) + i < 256) reloadMem[int'(al) + i] = d;
            end
            sum = sum + readHexByte();
            if (sum != 8'h00) parseErr++;
            if (parsePos >= gotQ.size() || gotQ[parsePos] != 8'h0A) parseErr++;
            parsePos++;
            if (tt == 8'h00) dataRecs++;
            if (tt == 8'h01) eofSeen = 1;
        end
    endtask

    initial begin
        int accepted;
        int dataRecs;
        int eofSeen;
        int diffCount;
        rstN = 1'b0;
        start = 1'b1;
        byteCount = 9'd3;
        outReady = 1'b1;
        for (int i = 0; i < 256; i++) romMem[i] = 8'h00;

        repeat (3) @(negedge clk);
        #1;
        checkOutput("reset_outputs", {busy, done, romRd, outValid, outData, 7'(romAddr)},
                    {1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 7'h00});
        start = 1'b0;
        @(negedge clk);
        rstN = 1'b1;
        @(negedge clk);
        #1;
        checkOutput("idle_after_reset", {busy, outValid}, 2'b00);

        $display("[TB] case 1: three bytes, ready always high");
        romMem[0] = 8'h0C; romMem[1] = 8'h94; romMem[2] = 8'h5C;
        applyStimulus(3, 0, -1, 400);
        loadExpectedString(":030000000C945C01\n:00000001FF\n");
        compareStreams("case1");
        checkOutput("case1_done_once", doneCount, 1);
        checkOutput("case1_rom_reads", rdCount, 3);

        $display("[TB] case 2: empty export");
        applyStimulus(0, 0, -1, 200);
        loadExpectedString(":00000001FF\n");
        compareStreams("case2");
        checkOutput("case2_no_rom_rd", rdCount, 0);
        checkOutput("case2_done_once", doneCount, 1);

        $display("[TB] case 3: 33 bytes with a start pulse while busy");
        for (int i = 0; i < 33; i++) romMem[i] = 8'($urandom);
        applyStimulus(33, 0, 40, 3000);
        buildExpected(33);
        checkOutput("case3_total_chars", gotQ.size(), 114);
        compareStreams("case3");
        checkOutput("case3_done_once", doneCount, 1);

        $display("[TB] case 4: case 1 with random ready");
        romMem[0] = 8'h0C; romMem[1] = 8'h94; romMem[2] = 8'h5C;
        applyStimulus(3, 1, -1, 2000);
        loadExpectedString(":030000000C945C01\n:00000001FF\n");
        compareStreams("case4");
        checkOutput("case4_done_once", doneCount, 1);

        $display("[TB] case 5: reset during second data digit");
        @(negedge clk);
        byteCount = 9'd3;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        outReady = 1'b1;
        accepted = 0;
        for (int c = 0; c < 100; c++) begin
            #1;
            if (accepted == 10 && outValid) break;
            if (outValid && outReady) accepted++;
            @(negedge clk);
        end
        checkOutput("case5_at_digit", {outValid, outData}, {1'b1, 8'h43});
        rstN = 1'b0;
        #1;
        checkOutput("case5_reset_immediate", {outValid, busy}, 2'b00);
        @(negedge clk);
        rstN = 1'b1;
        applyStimulus(3, 0, -1, 400);
        compareStreams("case5_restart");

        $display("[TB] case 6: clamped full-ROM round trip");
        for (int i = 0; i < 256; i++) romMem[i] = 8'($urandom);
        applyStimulus(9'h1FF, 1, -1, 8000);
        checkOutput("case6_total_chars", gotQ.size(), 716);
        buildExpected(256);
        compareStreams("case6");
        parseBinhex(dataRecs, eofSeen);
        checkOutput("case6_data_records", dataRecs, 16);
        checkOutput("case6_eof_seen", eofSeen, 1);
        checkOutput("case6_parse_errors", parseErr, 0);
        diffCount = 0;
        for (int i = 0; i < 256; i++) if (reloadMem[i] !== romMem[i]) diffCount++;
        checkOutput("case6_reload_equal", diffCount, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
